// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, datapath widths and the issue-slot record.
// Used by alu_share_arbiter (optional fixed-priority mode: ALU_ARB_PRIO0_EN).
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'd0;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'd1;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'd2;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'd6;
    localparam logic [CTRL_W-1:0] ALU_SLT = 4'd7;
    localparam logic [CTRL_W-1:0] ALU_NOR = 4'd12;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [CTRL_W-1:0] op;
    } alu_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_i, with wrap.
// Outputs a one-hot grant, its index and an any-request flag.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Two passes: positions above last_i first, then wrap to 0..last_i.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_o && req_i[i] && (i > int'(last_i))) begin
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
                any_o    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any_o && req_i[i] && (i <= int'(last_i))) begin
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among N_REQ requesters: arbitrate -> issue reg -> ALU -> response reg.
// Define ALU_ARB_PRIO0_EN to give requester 0 fixed top priority; others stay round-robin.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*DATA_W-1:0]  req_a,
    input  logic [N_REQ*DATA_W-1:0]  req_b,
    input  logic [N_REQ*CTRL_W-1:0]  req_op,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [CTRL_W-1:0]        alu_ctrl,
    input  logic [DATA_W-1:0]        alu_out,
    input  logic                     alu_zero,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_zero,
    output logic [ID_W-1:0]          rsp_id
);

    logic              s1_valid_q;
    alu_req_t          s1_q;
    logic [ID_W-1:0]   s1_id_q;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_zero_q;
    logic [ID_W-1:0]   rsp_id_q;

    logic [ID_W-1:0]   last_grant_q;
    logic [ID_W-1:0]   last_grant_d;

    logic              s2_free;
    logic              s1_adv;
    logic              s1_free;
    logic              xfer;

    logic [N_REQ-1:0]  pick_req;
    logic [N_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;

    logic [N_REQ-1:0]  win_gnt;
    logic [ID_W-1:0]   win_idx;
    logic              win_any;
    alu_req_t          win_op;

    assign s2_free = !rsp_valid_q || rsp_ready;
    assign s1_adv  = s1_valid_q && s2_free;
    assign s1_free = !s1_valid_q || s1_adv;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req_i  (pick_req),
        .last_i (last_grant_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

`ifdef ALU_ARB_PRIO0_EN
    // Requester 0 is masked out of the rotation; last_grant only tracks the others.
    assign pick_req = {req_valid[N_REQ-1:1], 1'b0};

    always_comb begin
        if (req_valid[0]) begin
            win_gnt = N_REQ'(1);
            win_idx = '0;
            win_any = 1'b1;
        end else begin
            win_gnt = pick_gnt;
            win_idx = pick_idx;
            win_any = pick_any;
        end
    end

    assign last_grant_d = (xfer && (win_idx != '0)) ? win_idx : last_grant_q;
`else
    assign pick_req = req_valid;

    always_comb begin
        win_gnt = pick_gnt;
        win_idx = pick_idx;
        win_any = pick_any;
    end

    assign last_grant_d = xfer ? win_idx : last_grant_q;
`endif

    always_comb begin
        win_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_gnt[i]) begin
                win_op.a  = req_a[DATA_W*i +: DATA_W];
                win_op.b  = req_b[DATA_W*i +: DATA_W];
                win_op.op = req_op[CTRL_W*i +: CTRL_W];
            end
        end
    end

    assign req_ready = (s1_free && win_any) ? win_gnt : '0;
    assign xfer      = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            s1_id_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
        end else begin
            if (xfer) begin
                s1_valid_q <= 1'b1;
                s1_q       <= win_op;
                s1_id_q    <= win_idx;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_adv) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= alu_out;
                rsp_zero_q  <= alu_zero;
                rsp_id_q    <= s1_id_q;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end

            last_grant_q <= last_grant_d;
        end
    end

    // Idle ALU inputs are forced to zero so a stale op never toggles the shared ALU.
    assign alu_a    = s1_valid_q ? s1_q.a  : '0;
    assign alu_b    = s1_valid_q ? s1_q.b  : '0;
    assign alu_ctrl = s1_valid_q ? s1_q.op : '0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_id    = rsp_id_q;

endmodule
